mod3_frame_tx: RTL and testbench
================================

// Module: mod3_frame_tx
// PURPOSE
//  Serial transmitter that makes frames divisible by three. Accepts a DATA_W-bit word, appends
//  a 2-bit check field so the (DATA_W+2)-bit frame is an exact multiple of 3, and shifts it out
//  LSB-first, one bit per accepted cycle. Sits at the sending end of the mod-3 serial link.
//  The team's serial divisible-by-3 checker at the far end reports 1 after the frame's last bit.
// PARAMETERS
//  DATA_W   8   payload width in bits, >= 2; frame length is DATA_W+2
// PORTS
//  clk        in   1       clock, all state updates on posedge
//  rst        in   1       synchronous reset, active-low
//  in_valid   in   1       payload word offered
//  in_ready   out  1       block can accept a word
//  in_data    in   DATA_W  payload word, sampled on accept
//  out        out  1       serial frame bit, LSB first
//  out_valid  out  1       out carries a frame bit
//  out_ready  in   1       downstream takes the bit this cycle
//  out_last   out  1       high with the final (check MSB) bit of a frame
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state IDLE, in_ready=1, out=0, out_valid=0, out_last=0,
//    bit counter=0, residue=0. Reset mid-frame drops the frame, with no partial completion.
//  - Accept: in_valid&&in_ready at posedge. Load shift reg; go to DATA. out_valid=1 next cycle.
//  - Bit advance: only on out_valid&&out_ready; otherwise out/out_valid/out_last hold stable.
//  - FSM: IDLE -accept-> DATA -DATA_W bits sent-> CHECK -2 bits sent-> IDLE.
//    in_ready=1 only in IDLE. One idle cycle always separates frames.
//  - Running residue r (0..2) uses the checker recurrence. Bit i has weight 2^i mod 3:
//    1 for even i, 2 for odd i. On each DATA bit sent, r <= (r + bit*weight) % 3.
//    Weight toggles every bit and starts at 1.
//  - Check field c (2 bits, value 0..2; 3 never sent), fixed when the last DATA bit is sent:
//    DATA_W even: c = (3 - r) % 3.   DATA_W odd: c = r.
//  - Frame invariant: (in_data + c*2^DATA_W) % 3 == 0.
//  - CHECK phase sends c[0] then c[1]. out_last=1 only while c[1] is presented.
//  - After the out_last handshake: IDLE, out_valid=0, out=0, residue and counter cleared.
//  - Latency: accept at edge N gives bit 0 valid in cycle N+1. Without stall, last bit is in
//    cycle N+DATA_W+2.
//  - Bit counter width: $clog2(DATA_W+2). It never wraps within a frame.
//  - in_valid during DATA/CHECK is ignored. The source holds the word until in_ready.
// STRUCTURE
//  - Package mod3_pkg: FSM state encoding (IDLE, DATA, CHECK), residue width constant (2).
//    Also holds function mod3_next(r, bit, weight).
//  - Sub-module mod3_acc: residue register plus weight toggle, with clear and enable inputs.
//    The top holds the FSM, shift register, counter and check-bit mux.
// TESTING (DATA_W=8 unless noted; out_ready=1 unless noted)
//  1. in_data=8'h00 -> 10 bits all 0, c=0; out_last on bit 9; in_ready returns 1 cycle later.
//  2. in_data=8'h05 (r=2) -> bits 1,0,1,0,0,0,0,0 then c=1 (1,0); frame 261 = 3*87.
//  3. in_data=8'h07 (r=1) -> c=2, check bits 0,1; frame 519 = 3*173.
//  4. DATA_W=7, in_data=7'h01 (r=1) -> c=1; frame 129 = 3*43. Also 7'h7F: frame % 3 == 0.
//  5. out_ready=0 for 3 cycles at bit 4 of 8'hA5 -> out/out_valid held; frame bits unchanged.
//     Total duration is 13 cycles.
//  6. Drive rst=0 at bit 5 -> next cycle out_valid=0, in_ready=1. Next word 8'h03 gives c=0
//     with residue starting at 0.
//  Loopback: 256 random words into the checker -> its output is 1 after every out_last bit.

Source files
------------

// File: rtl/mod3_pkg.sv
// Shared types and helpers for the mod-3 frame transmitter: FSM states,
// residue width and the serial divisible-by-3 recurrence step.
package mod3_pkg;

  localparam int RES_W = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_CHECK
  } state_t;

  // Bit weight is 2^i mod 3: 1 on even positions, 2 on odd ones.
  function automatic logic [RES_W-1:0] mod3_next(input logic [RES_W-1:0] r,
                                                 input logic             b,
                                                 input logic             w_odd);
    logic [2:0] sum;
    sum = {1'b0, r} + (b ? (w_odd ? 3'd2 : 3'd1) : 3'd0);
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

endpackage

// File: rtl/mod3_frame_tx_acc.sv
// Running mod-3 residue of the bits sent so far, with the alternating
// 1/2 bit weight. Exposes the residue including the bit being sent now.
module mod3_acc
  import mod3_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [RES_W-1:0] o_res_nxt
);

  logic [RES_W-1:0] r_res;
  logic             r_w_odd;

  assign o_res_nxt = mod3_next(r_res, i_bit, r_w_odd);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_res   <= '0;
      r_w_odd <= 1'b0;
    end else if (i_en) begin
      r_res   <= o_res_nxt;
      r_w_odd <= ~r_w_odd;
    end
  end

endmodule

// File: rtl/mod3_frame_tx.sv
// Serial transmitter: shifts a DATA_W-bit word out LSB-first followed by a
// 2-bit check field that makes the whole frame a multiple of three.
module mod3_frame_tx
  import mod3_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_chk_hi;
  logic              r_in_ready;
  logic              r_out;
  logic              r_out_valid;
  logic              r_out_last;

  logic              w_accept;
  logic              w_fire;
  logic              w_acc_en;
  logic              w_acc_clr;
  logic [RES_W-1:0]  w_res_nxt;
  logic [RES_W-1:0]  w_chk;

  assign w_accept  = in_valid && r_in_ready;
  assign w_fire    = r_out_valid && out_ready;
  assign w_acc_en  = w_fire && (r_state == S_DATA);
  assign w_acc_clr = w_accept || (w_fire && r_out_last);

  mod3_acc u_acc (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_acc_clr),
    .i_en      (w_acc_en),
    .i_bit     (r_out),
    .o_res_nxt (w_res_nxt)
  );

  // With an even payload width the check field sits on weight 1, so it must
  // cancel the residue; with an odd width it sits on weight 2 and equals it.
  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    w_chk = w_res_nxt;
    if (DATA_W % 2 == 0) begin
      case (w_res_nxt)
        2'd1:    w_chk = 2'd2;
        2'd2:    w_chk = 2'd1;
        default: w_chk = 2'd0;
      endcase
    end
  end

  // NOTE: the shift register carries no reset; it is always reloaded on accept
  // before any of its bits reach the output.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift <= in_data;
    end else if (w_acc_en) begin
      r_shift <= {1'b0, r_shift[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_cnt       <= '0;
      r_chk_hi    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_out       <= in_data[0];
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_fire) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_DATA) begin
              r_chk_hi <= w_chk[1];
              r_out    <= w_chk[0];
              r_state  <= S_CHECK;
            end else begin
              r_out <= r_shift[1];
            end
          end
        end
        S_CHECK: begin
          if (w_fire) begin
            if (!r_out_last) begin
              r_out      <= r_chk_hi;
              r_out_last <= 1'b1;
              r_cnt      <= r_cnt + 1'b1;
            end else begin
              r_out       <= 1'b0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_in_ready  <= 1'b1;
              r_cnt       <= '0;
              r_state     <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_mod3_frame_tx.sv
// Directed bench for mod3_frame_tx at DATA_W=8 and DATA_W=7, with a far-end
// divisible-by-3 checker model applied to every received frame.
module tb_mod3_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       out_ready;
  logic       iv8, ir8, o8, ov8, ol8;
  logic [7:0] d8;
  logic       iv7, ir7, o7, ov7, ol7;
  logic [6:0] d7;

  logic sel7;
  logic s_ir, s_out, s_ov, s_ol;
  assign s_ir  = sel7 ? ir7 : ir8;
  assign s_out = sel7 ? o7  : o8;
  assign s_ov  = sel7 ? ov7 : ov8;
  assign s_ol  = sel7 ? ol7 : ol8;

  mod3_frame_tx #(.DATA_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(d8),
    .out(o8), .out_valid(ov8), .out_ready(out_ready), .out_last(ol8)
  );

  mod3_frame_tx #(.DATA_W(7)) u_dut7 (
    .clk(clk), .rst(rst), .in_valid(iv7), .in_ready(ir7), .in_data(d7),
    .out(o7), .out_valid(ov7), .out_ready(out_ready), .out_last(ol7)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check field chosen so that d + c*2^w is a multiple of 3.
  function automatic int exp_c(input int d, input int w);
    for (int c = 0; c < 3; c++)
      if ((d + c * (1 << w)) % 3 == 0) return c;
    return 3;
  endfunction

  // Sends one word on the selected DUT and checks the frame it emits.
  // exp_frame < 0 derives the frame from exp_c; abort_bit >= 0 pulses reset
  // while that bit is presented.
  task automatic send(input string tag, input int d, input int exp_frame,
                      input int stall_bit, input int stall_n, input int abort_bit);
    int w = sel7 ? 7 : 8;
    int len = w + 2;
    int mask = (1 << len) - 1;
    int ef;
    int idx = 0, cyc = 0, stalled = 0, r = 0, wt = 1;
    logic [9:0] bits = '0;
    logic held = 1'b0;
    bit last_ok = 1'b1;
    bit done = 1'b0, aborted = 1'b0;

    ef = (exp_frame >= 0) ? exp_frame : (d + (exp_c(d, w) << w));
    chk({tag, ":in_ready"}, 32'(s_ir), 32'd1);
    if (sel7) begin d7 = 7'(d); iv7 = 1'b1; end
    else      begin d8 = 8'(d); iv8 = 1'b1; end
    @(posedge clk); #1;
    iv7 = 1'b0; iv8 = 1'b0;

    while (!done && cyc < 100) begin
      cyc++;
      if (s_ov !== 1'b1) begin
        chk({tag, ":out_valid_in_frame"}, 32'(s_ov), 32'd1);
        done = 1'b1;
      end else if (idx == abort_bit) begin
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        aborted = 1'b1;
        done = 1'b1;
      end else if (idx == stall_bit && stalled < stall_n) begin
        if (stalled == 0) held = s_out;
        else chk({tag, ":stall_hold"}, 32'(s_out), 32'(held));
        out_ready = 1'b0;
        stalled++;
        @(posedge clk); #1;
      end else begin
        if (stalled > 0 && idx == stall_bit)
          chk({tag, ":stall_release"}, 32'(s_out), 32'(held));
        out_ready = 1'b1;
        bits[idx] = s_out;
        if (s_ol !== (idx == len - 1)) last_ok = 1'b0;
        if (s_out) r = (r + wt) % 3;
        wt = 3 - wt;
        if (idx == len - 1) done = 1'b1;
        idx++;
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;

    if (!done) chk({tag, ":timeout"}, 32'(cyc), 32'd0);
    if (aborted) begin
      chk({tag, ":abort_out_valid"}, 32'(s_ov), 32'd0);
      chk({tag, ":abort_in_ready"},  32'(s_ir), 32'd1);
      chk({tag, ":abort_out"},       32'(s_out), 32'd0);
    end else if (done && idx == len) begin
      chk({tag, ":frame"},       32'(int'(bits) & mask), 32'(ef));
      chk({tag, ":out_last"},    32'(last_ok), 32'd1);
      chk({tag, ":cycles"},      32'(cyc), 32'(len + stall_n));
      chk({tag, ":checker"},     32'(r), 32'd0);
      chk({tag, ":idle_valid"},  32'(s_ov), 32'd0);
      chk({tag, ":idle_out"},    32'(s_out), 32'd0);
      chk({tag, ":idle_ready"},  32'(s_ir), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b0; out_ready = 1'b1; sel7 = 1'b0;
    iv8 = 1'b0; iv7 = 1'b0; d8 = '0; d7 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset:in_ready",  32'(ir8), 32'd1);
    chk("reset:out_valid", 32'(ov8), 32'd0);
    chk("reset:out",       32'(o8),  32'd0);
    chk("reset:out_last",  32'(ol8), 32'd0);
    chk("reset7:in_ready", 32'(ir7), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    send("zero",  8'h00, 32'h000, -1, 0, -1);
    send("d05",   8'h05, 32'h105, -1, 0, -1);
    send("d07",   8'h07, 32'h207, -1, 0, -1);
    send("stall", 8'hA5, -1, 4, 3, -1);
    send("abort", 8'h5B, -1, -1, 0, 5);
    send("d03",   8'h03, 32'h003, -1, 0, -1);
    send("dff",   8'hFF, -1, -1, 0, -1);

    sel7 = 1'b1;
    send("w7_d01", 7'h01, 32'h081, -1, 0, -1);
    send("w7_d7f", 7'h7F, 32'h0FF, -1, 0, -1);
    send("w7_d02", 7'h02, -1, -1, 0, -1);
    sel7 = 1'b0;

    for (int i = 0; i < 256; i++) begin
      int d;
      d = int'($urandom_range(0, 255));
      send("loop", d, -1, -1, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
